// File: rtl/keypad_pkg.sv
// Shared key codes, debounce state encoding and the keypad position-to-code map.
package keypad_pkg;

    localparam logic [3:0] KEY_CLEAR = 4'hA;
    localparam logic [3:0] KEY_BKSP  = 4'hB;
    localparam logic [3:0] KEY_BLANK = 4'hF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONFIRM = 2'd1,
        HELD    = 2'd2,
        RELEASE = 2'd3
    } db_state_e;

    // Returns {known, code}. known=0 marks a position that carries no key.
    function automatic logic [4:0] key_lookup(input int unsigned r,
                                              input int unsigned c,
                                              input int unsigned rows,
                                              input int unsigned cols);
        int unsigned pos;
        logic [4:0]  res;
        res = {1'b0, KEY_BLANK};
        pos = r * cols + c;
        if (rows == 4 && cols == 3) begin
            // Classic phone layout: 1..9 on top, CLEAR / 0 / BKSP on the bottom row.
            if (r < 3)       res = {1'b1, 4'(3 * r + c + 1)};
            else if (c == 0) res = {1'b1, KEY_CLEAR};
            else if (c == 1) res = {1'b1, 4'h0};
            else             res = {1'b1, KEY_BKSP};
        end else if (pos < 10) begin
            res = {1'b1, 4'((pos + 1) % 10)};
        end
        return res;
    endfunction

endpackage

// File: rtl/keypad_debounce_fsm.sv
// Frame-rate debouncer: accepts a key once after DEBOUNCE identical frames and
// requires DEBOUNCE empty frames before another press can be accepted.
module keypad_debounce_fsm
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic [3:0] frame_key,
    input  logic       frame_none,
    output logic       accept,
    output logic [3:0] accepted_code
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_TGT = CW'(DEBOUNCE);

    db_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_inc;

    assign cnt_inc = cnt_q + CNT_ONE;

    // State, run counter and candidate key registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cand_q  <= KEY_BLANK;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
        end
    end

    // Next-state logic, evaluated only on frame boundaries; accept is a same-cycle strobe.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cand_d        = cand_q;
        accept        = 1'b0;
        accepted_code = frame_key;
        if (frame_tick) begin
            case (state_q)
                IDLE: begin
                    if (!frame_none) begin
                        cand_d = frame_key;
                        if (DEBOUNCE == 1) begin
                            accept  = 1'b1;
                            state_d = HELD;
                        end else begin
                            state_d = CONFIRM;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                CONFIRM: begin
                    if (frame_none) begin
                        state_d = IDLE;
                    end else if (frame_key != cand_q) begin
                        cand_d = frame_key;
                        cnt_d  = CNT_ONE;
                    end else if (cnt_inc == CNT_TGT) begin
                        accept  = 1'b1;
                        state_d = HELD;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                HELD: begin
                    if (frame_none) begin
                        if (DEBOUNCE == 1) begin
                            state_d = IDLE;
                        end else begin
                            state_d = RELEASE;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                RELEASE: begin
                    if (!frame_none) begin
                        state_d = HELD;
                    end else if (cnt_inc == CNT_TGT) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Matrix keypad scanner with frame-level ghost rejection, debounced acceptance
// and a right-aligned N-digit entry buffer multiplexed onto a digit display.
module keypad_entry_ctrl
    import keypad_pkg::*;
#(
    parameter int ROWS     = 4,
    parameter int COLS     = 3,
    parameter int DIGITS   = 6,
    parameter int SCAN_DIV = 8192,
    parameter int DEBOUNCE = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [COLS-1:0]               col_n,
    output logic [$clog2(ROWS)-1:0]       row_sel,
    output logic [$clog2(DIGITS)-1:0]     digit_sel,
    output logic [3:0]                    digit_code,
    output logic                          key_valid,
    output logic [3:0]                    key_code,
    output logic [$clog2(DIGITS+1)-1:0]   entry_count,
    output logic                          full
);

    localparam int RW  = $clog2(ROWS);
    localparam int DW  = $clog2(DIGITS);
    localparam int CW  = $clog2(DIGITS + 1);
    localparam int TW  = $clog2(SCAN_DIV);
    localparam int CLW = $clog2(COLS);
    localparam logic [COLS-1:0] COL_ONE = COLS'(1);

    // Synchroniser
    logic [COLS-1:0] col_meta_q, col_meta_d;
    logic [COLS-1:0] col_sync_q, col_sync_d;

    // Scan timing
    logic [TW-1:0] dwell_q, dwell_d;
    logic [RW-1:0] row_q, row_d;
    logic [DW-1:0] digit_q, digit_d;
    logic          tc;
    logic          frame_tick;

    // Frame collector
    logic [COLS-1:0] pressed;
    logic            row_any, row_multi;
    logic [CLW-1:0]  hit_col;
    logic            seen_q, seen_d, ghost_q, ghost_d;
    logic [RW-1:0]   hit_row_q, hit_row_d;
    logic [CLW-1:0]  hit_col_q, hit_col_d;
    logic            seen_all, ghost_all;
    logic [RW-1:0]   row_all;
    logic [CLW-1:0]  col_all;
    logic [4:0]      lookup;
    logic [3:0]      frame_key;
    logic            frame_none;

    // Debounce interface
    logic       accept;
    logic [3:0] accepted_code;

    // Entry buffer
    logic [3:0]    digits_q [DIGITS];
    logic [3:0]    digits_d [DIGITS];
    logic [CW-1:0] count_q, count_d;
    logic          key_valid_q, key_valid_d;
    logic [3:0]    key_code_q, key_code_d;

    // All state registers; columns idle high so the synchroniser resets to "no key".
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_meta_q  <= '1;
            col_sync_q  <= '1;
            dwell_q     <= '0;
            row_q       <= '0;
            digit_q     <= '0;
            seen_q      <= 1'b0;
            ghost_q     <= 1'b0;
            hit_row_q   <= '0;
            hit_col_q   <= '0;
            count_q     <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= KEY_BLANK;
            for (int i = 0; i < DIGITS; i++) digits_q[i] <= KEY_BLANK;
        end else begin
            col_meta_q  <= col_meta_d;
            col_sync_q  <= col_sync_d;
            dwell_q     <= dwell_d;
            row_q       <= row_d;
            digit_q     <= digit_d;
            seen_q      <= seen_d;
            ghost_q     <= ghost_d;
            hit_row_q   <= hit_row_d;
            hit_col_q   <= hit_col_d;
            count_q     <= count_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            for (int i = 0; i < DIGITS; i++) digits_q[i] <= digits_d[i];
        end
    end

    // Two-flop synchroniser and the shared row/digit dwell counter.
    always_comb begin
        col_meta_d = col_n;
        col_sync_d = col_meta_q;
        tc         = (dwell_q == TW'(SCAN_DIV - 1));
        dwell_d    = tc ? '0 : dwell_q + TW'(1);
        row_d      = row_q;
        digit_d    = digit_q;
        if (tc) begin
            row_d   = (row_q == RW'(ROWS - 1))     ? '0 : row_q + RW'(1);
            digit_d = (digit_q == DW'(DIGITS - 1)) ? '0 : digit_q + DW'(1);
        end
        frame_tick = tc && (row_q == RW'(ROWS - 1));
    end

    // Accumulate one frame of row samples; a second press anywhere marks the frame as ghosted.
    always_comb begin
        pressed   = ~col_sync_q;
        row_any   = |pressed;
        row_multi = (pressed & (pressed - COL_ONE)) != '0;
        hit_col   = '0;
        for (int c = 0; c < COLS; c++) begin
            if (pressed[c]) hit_col = CLW'(c);
        end

        seen_all  = seen_q;
        ghost_all = ghost_q;
        row_all   = hit_row_q;
        col_all   = hit_col_q;
        if (tc && row_any) begin
            if (seen_q || row_multi) ghost_all = 1'b1;
            seen_all = 1'b1;
            row_all  = row_q;
            col_all  = hit_col;
        end

        seen_d    = seen_all;
        ghost_d   = ghost_all;
        hit_row_d = row_all;
        hit_col_d = col_all;
        if (frame_tick) begin
            seen_d    = 1'b0;
            ghost_d   = 1'b0;
            hit_row_d = '0;
            hit_col_d = '0;
        end else if (!tc) begin
            seen_d    = seen_q;
            ghost_d   = ghost_q;
            hit_row_d = hit_row_q;
            hit_col_d = hit_col_q;
        end

        lookup     = key_lookup(32'(row_all), 32'(col_all), ROWS, COLS);
        frame_key  = lookup[3:0];
        frame_none = !seen_all || ghost_all || !lookup[4];
    end

    keypad_debounce_fsm #(
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .clk           (clk),
        .reset         (reset),
        .frame_tick    (frame_tick),
        .frame_key     (frame_key),
        .frame_none    (frame_none),
        .accept        (accept),
        .accepted_code (accepted_code)
    );

    // Apply an accepted key to the entry buffer: digits shift in from the right.
    always_comb begin
        digits_d    = digits_q;
        count_d     = count_q;
        key_valid_d = accept;
        key_code_d  = key_code_q;
        if (accept) begin
            key_code_d = accepted_code;
            if (accepted_code == KEY_CLEAR) begin
                for (int i = 0; i < DIGITS; i++) digits_d[i] = KEY_BLANK;
                count_d = '0;
            end else if (accepted_code == KEY_BKSP) begin
                if (count_q != '0) begin
                    for (int i = DIGITS - 1; i > 0; i--) digits_d[i] = digits_q[i-1];
                    digits_d[0] = KEY_BLANK;
                    count_d     = count_q - CW'(1);
                end
            end else if (count_q != CW'(DIGITS)) begin
                for (int i = 0; i < DIGITS - 1; i++) digits_d[i] = digits_q[i+1];
                digits_d[DIGITS-1] = accepted_code;
                count_d            = count_q + CW'(1);
            end
        end
    end

    assign row_sel     = row_q;
    assign digit_sel   = digit_q;
    assign digit_code  = (digit_q < DW'(DIGITS - 1) || digit_q == DW'(DIGITS - 1)) ? digits_q[digit_q] : KEY_BLANK;
    assign key_valid   = key_valid_q;
    assign key_code    = key_code_q;
    assign entry_count = count_q;
    assign full        = (count_q == CW'(DIGITS));

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Bench for keypad_entry_ctrl: frame-level keypad stimulus checked against a
// behavioural model of debounce acceptance and a right-aligned digit list.
`timescale 1ns/1ps
module tb_keypad_entry_ctrl;

    localparam int ROWS     = 4;
    localparam int COLS     = 3;
    localparam int DIGITS   = 6;
    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 2;
    localparam int FRAME    = ROWS * SCAN_DIV;
    localparam int NONE     = -1;
    localparam int NKEYS    = ROWS * COLS;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [COLS-1:0]  col_n;
    logic [1:0]       row_sel;
    logic [2:0]       digit_sel;
    logic [3:0]       digit_code;
    logic             key_valid;
    logic [3:0]       key_code;
    logic [2:0]       entry_count;
    logic             full;

    logic [NKEYS-1:0] pressed = '0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int pulse_cnt = 0;

    // Model state
    int last_res;
    int run;
    bit latched;
    int entries[$];
    int exp_code;
    int model_accepts = 0;

    keypad_entry_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .DIGITS(DIGITS),
        .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)
    ) dut (
        .clk(clk), .reset(reset), .col_n(col_n),
        .row_sel(row_sel), .digit_sel(digit_sel), .digit_code(digit_code),
        .key_valid(key_valid), .key_code(key_code),
        .entry_count(entry_count), .full(full)
    );

    always #5 clk = ~clk;

    // Physical keypad: a pressed key pulls its column low while its row is strobed.
    always_comb begin
        for (int c = 0; c < COLS; c++) col_n[c] = ~pressed[int'(row_sel) * COLS + c];
    end

    always @(negedge clk) begin
        if (!reset && key_valid === 1'b1) pulse_cnt++;
    end

    // Key code printed on the keypad at a given position index (row*COLS+col).
    function automatic int key_of(input int idx);
        if (idx < 9)   return idx + 1;
        if (idx == 9)  return 10;
        if (idx == 10) return 0;
        if (idx == 11) return 11;
        return NONE;
    endfunction

    // Position index of the key that produces a given code.
    function automatic int idx_of(input int code);
        for (int i = 0; i < NKEYS; i++) if (key_of(i) == code) return i;
        return 0;
    endfunction

    function automatic logic [NKEYS-1:0] kb(input int code);
        logic [NKEYS-1:0] v;
        v = '0;
        v[idx_of(code)] = 1'b1;
        return v;
    endfunction

    function automatic int frame_result(input logic [NKEYS-1:0] k);
        if ($countones(k) != 1) return NONE;
        for (int i = 0; i < NKEYS; i++) if (k[i]) return key_of(i);
        return NONE;
    endfunction

    function automatic int model_disp(input int i);
        int n;
        n = entries.size();
        if (i >= DIGITS - n) return entries[i - (DIGITS - n)];
        return 15;
    endfunction

    task automatic model_reset();
        last_res = NONE;
        run      = 0;
        latched  = 0;
        entries.delete();
        exp_code = 15;
    endtask

    // A key is taken once DEBOUNCE identical frames are seen while nothing is latched;
    // the latch clears after DEBOUNCE consecutive empty frames.
    task automatic model_frame(input int res, output bit acc);
        acc = 0;
        if (res == last_res) run++;
        else begin
            run      = 1;
            last_res = res;
        end
        if (latched) begin
            if (res == NONE && run >= DEBOUNCE) latched = 0;
        end else if (res != NONE && run >= DEBOUNCE) begin
            latched = 1;
            acc     = 1;
            model_accepts++;
            exp_code = res;
            if (res == 10) entries.delete();
            else if (res == 11) begin
                if (entries.size() > 0) void'(entries.pop_back());
            end else if (entries.size() < DIGITS) entries.push_back(res);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cyc   = 0;
        model_reset();
    endtask

    // Hold a key pattern for one whole frame, checking scan and display each cycle
    // and the acceptance outputs on the cycle after the frame end.
    task automatic run_frame(input logic [NKEYS-1:0] keys);
        bit acc;
        int res;
        pressed = keys;
        for (int i = 0; i < FRAME; i++) begin
            checks++;
            if (row_sel !== 2'((cyc / SCAN_DIV) % ROWS) || digit_sel !== 3'((cyc / SCAN_DIV) % DIGITS)) begin
                errors++;
                $display("FAIL scan cyc=%0d row_sel=%0d digit_sel=%0d expected row %0d digit %0d",
                         cyc, row_sel, digit_sel, (cyc / SCAN_DIV) % ROWS, (cyc / SCAN_DIV) % DIGITS);
            end
            checks++;
            if (digit_code !== 4'(model_disp(int'(digit_sel)))) begin
                errors++;
                $display("FAIL digit_code cyc=%0d digit_sel=%0d got %h expected %h",
                         cyc, digit_sel, digit_code, 4'(model_disp(int'(digit_sel))));
            end
            @(negedge clk);
            cyc++;
        end
        res = frame_result(keys);
        model_frame(res, acc);
        checks++;
        if (key_valid !== acc) begin
            errors++;
            $display("FAIL key_valid cyc=%0d got %b expected %b", cyc, key_valid, acc);
        end
        checks++;
        if (key_code !== 4'(exp_code)) begin
            errors++;
            $display("FAIL key_code cyc=%0d got %h expected %h", cyc, key_code, 4'(exp_code));
        end
        checks++;
        if (entry_count !== 3'(entries.size())) begin
            errors++;
            $display("FAIL entry_count cyc=%0d got %0d expected %0d", cyc, entry_count, entries.size());
        end
        checks++;
        if (full !== (entries.size() == DIGITS)) begin
            errors++;
            $display("FAIL full cyc=%0d got %b expected %b", cyc, full, entries.size() == DIGITS);
        end
    endtask

    task automatic press(input int code, input int on_frames, input int off_frames);
        for (int f = 0; f < on_frames; f++) run_frame(kb(code));
        for (int f = 0; f < off_frames; f++) run_frame('0);
    endtask

    task automatic expect_int(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (row_sel !== 2'd0 || digit_sel !== 3'd0 || digit_code !== 4'hF || key_valid !== 1'b0 ||
            key_code !== 4'hF || entry_count !== 3'd0 || full !== 1'b0) begin
            errors++;
            $display("FAIL reset_state row=%0d dig=%0d code=%h kv=%b kc=%h cnt=%0d full=%b expected 0 0 f 0 f 0 0",
                     row_sel, digit_sel, digit_code, key_valid, key_code, entry_count, full);
        end
        reset = 1'b0;
        cyc   = 0;
        model_reset();
        run_frame('0);
    endtask

    task automatic test_single_press();
        int p0;
        do_reset();
        p0 = pulse_cnt;
        press(2, 5, 3);
        expect_int("single_pulses", pulse_cnt - p0, 1);
        expect_int("single_code", int'(key_code), 2);
        expect_int("single_count", int'(entry_count), 1);
    endtask

    task automatic test_fill();
        int p0;
        do_reset();
        p0 = pulse_cnt;
        for (int d = 1; d <= 7; d++) press(d, 3, 3);
        expect_int("fill_pulses", pulse_cnt - p0, 7);
        expect_int("fill_count", int'(entry_count), 6);
        expect_int("fill_full", int'(full), 1);
        expect_int("fill_code", int'(key_code), 7);
    endtask

    task automatic test_edit();
        do_reset();
        press(1, 3, 3);
        press(2, 3, 3);
        press(11, 3, 3);
        expect_int("bksp_count", int'(entry_count), 1);
        expect_int("bksp_code", int'(key_code), 11);
        press(10, 3, 3);
        expect_int("clear_count", int'(entry_count), 0);
        press(11, 3, 3);
        expect_int("bksp_empty_count", int'(entry_count), 0);
    endtask

    task automatic test_ghost_glitch();
        int p0;
        do_reset();
        p0 = pulse_cnt;
        for (int f = 0; f < 5; f++) run_frame(kb(1) | kb(6));
        run_frame('0);
        run_frame('0);
        press(4, 1, 3);
        expect_int("ghost_glitch_pulses", pulse_cnt - p0, 0);
    endtask

    task automatic test_bounce();
        int p0;
        do_reset();
        p0 = pulse_cnt;
        press(5, 3, 1);
        press(5, 3, 3);
        expect_int("bounce_pulses", pulse_cnt - p0, 1);
    endtask

    task automatic test_reset_held();
        int p0;
        do_reset();
        p0 = pulse_cnt;
        press(8, 3, 0);
        pressed = kb(8);
        repeat (7) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (digit_code !== 4'hF || entry_count !== 3'd0 || key_code !== 4'hF || key_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset code=%h cnt=%0d kc=%h kv=%b expected f 0 f 0",
                     digit_code, entry_count, key_code, key_valid);
        end
        @(negedge clk);
        reset = 1'b0;
        cyc   = 0;
        model_reset();
        for (int f = 0; f < 3; f++) run_frame(kb(8));
        expect_int("reheld_pulses", pulse_cnt - p0, 2);
        expect_int("reheld_count", int'(entry_count), 1);
    endtask

    task automatic test_random();
        int p0, a0, kind, dur, k1, k2;
        logic [NKEYS-1:0] pat;
        do_reset();
        p0 = pulse_cnt;
        a0 = model_accepts;
        for (int s = 0; s < 40; s++) begin
            kind = $urandom_range(0, 9);
            dur  = $urandom_range(1, 4);
            pat  = '0;
            k1   = $urandom_range(0, NKEYS - 1);
            k2   = (k1 + $urandom_range(1, NKEYS - 1)) % NKEYS;
            if (kind >= 3) pat[k1] = 1'b1;
            if (kind == 9) pat[k2] = 1'b1;
            for (int f = 0; f < dur; f++) run_frame(pat);
        end
        for (int f = 0; f < 3; f++) run_frame('0);
        expect_int("random_pulses", pulse_cnt - p0, model_accepts - a0);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_press();
        test_fill();
        test_edit();
        test_ghost_glitch();
        test_bounce();
        test_reset_held();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_entry_ctrl.md
# keypad_entry_ctrl

Parametrised matrix-keypad entry controller with a multi-digit display. It drives row strobes, samples active-low columns once per row dwell, and debounces whole scan frames. Each press is accepted exactly once, with release required before the next press, and feeds an N-digit entry buffer that supports clear and backspace. It sits between the board keypad/7-segment pins and the BCD-to-segment decoder, and replaces the fixed 3-column, 6-digit keypad path.

## Interface
- ROWS, 4, keypad rows scanned (≥2)
- COLS, 3, keypad columns (≥2)
- DIGITS, 6, entry buffer/display digits (≥2)
- SCAN_DIV, 8192, clk cycles per row/digit dwell (≥2)
- DEBOUNCE, 3, consecutive identical frames needed to accept press or release (≥1)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- col_n  in  COLS  column inputs, active-low, asynchronous to clk
- row_sel  out  clog2(ROWS)  row currently strobed
- digit_sel  out  clog2(DIGITS)  display digit currently enabled
- digit_code  out  4  code for digit_sel; 4'hF = blank
- key_valid  out  1  one-cycle pulse on accepted press
- key_code  out  4  code of last accepted key
- entry_count  out  clog2(DIGITS+1)  digits currently held
- full  out  1  entry_count == DIGITS

## Operation
- col_n passes through a 2-flop synchroniser before any use.
- Dwell counter runs 0..SCAN_DIV-1. At terminal count, row_sel and digit_sel each advance by 1, wrapping ROWS-1→0 and DIGITS-1→0.
- Columns are sampled on the terminal-count cycle of each row. A frame is ROWS consecutive row samples and ends at the row ROWS-1 sample.
- Frame result is the single pressed key (row r, col c). If no key is pressed, the result is NONE. If two or more keys are pressed anywhere in the frame, the result is also NONE (ghost rejection).
- Key map for ROWS=4, COLS=3: rows 0–2 give 1..9 (code = 3r+c+1). Row 3 gives col0 = CLEAR (4'hA), col1 = 0, col2 = BKSP (4'hB). For other geometries, code = (r·COLS+c+1) mod 10 for positions below 10; all other positions are ignored keys (NONE).
- Debounce FSM is evaluated once per frame end:
  - IDLE: key K → CONFIRM(K, cnt=1); NONE → stay.
  - CONFIRM: same K → cnt+1, and on reaching DEBOUNCE → accept and go to HELD. Different key → CONFIRM(new, 1). NONE → IDLE.
  - HELD: NONE → RELEASE(cnt=1); any key → stay (no repeat).
  - RELEASE: NONE → cnt+1, and on reaching DEBOUNCE → IDLE. Any key → HELD.
  - With DEBOUNCE=1, acceptance happens on the first frame showing the key.
- Accept: key_valid=1 for one cycle and key_code updated. Buffer action:
  - Digit 0–9: if not full, shift left and insert at digit DIGITS-1 (rightmost); entry_count+1. If full, ignore; key_valid still pulses.
  - CLEAR: all digits ← 4'hF, entry_count ← 0.
  - BKSP: shift right, insert 4'hF at digit 0, entry_count−1. When entry_count is 0, no change.
- digit_code = buf[digit_sel]; digit 0 is leftmost.

## Timing
- Reset values: row_sel=0, digit_sel=0, dwell=0, FSM=IDLE, all digits 4'hF, digit_code=4'hF, key_valid=0, key_code=4'hF, entry_count=0, full=0.
- Reset mid-press: the FSM returns to IDLE, so a still-held key is accepted again after DEBOUNCE frames.
- key_valid asserts on the cycle after the final frame-end sample. key_code, buffer, entry_count and full update on that same edge.
- Column change to accept latency: 2 sync cycles + up to DEBOUNCE+1 frames.
- row_sel and digit_sel change on the same edge. digit_code is combinational from digit_sel and buf.

## Structure
- Shared package keypad_pkg: KEY_CLEAR=4'hA, KEY_BKSP=4'hB, KEY_BLANK=4'hF, debounce state enum {IDLE, CONFIRM, HELD, RELEASE}.
- Sub-module keypad_debounce_fsm: inputs frame_tick, frame_key, frame_none; outputs accept, accepted_code; parameter DEBOUNCE.
- The scan counter, frame collector, buffer and mux live in the top level.

## Test plan
Bench parameters: SCAN_DIV=4, DEBOUNCE=2, defaults otherwise.
- Press r0c1 ("2") for 5 frames, then release → exactly one key_valid, key_code=2, digits F F F F F 2, entry_count=1.
- Enter 1,2,3,4,5,6, then 7 → buffer 1 2 3 4 5 6, full=1, 7 is not stored, 7 frames' worth of key_valid pulses total (one per key).
- After "12", press BKSP → F F F F F 1, count=1. Press CLEAR → all F, count=0.
- Hold r0c0 and r1c2 together for 5 frames → no key_valid. Glitch of 1 frame → no key_valid.
- Press 5, release for 1 frame, press again for 3 frames → one key_valid only.
- Assert reset while HELD on "8" with buffer "8" → buffer all F immediately. "8" is re-accepted 2 frames after reset release.
